// File: rtl/clock_div_ctrl_pkg.sv
// Shared types and defaults for the hash-core clock divider controller.
package clock_div_pkg;

    localparam int CNT_W       = 4;
    localparam int DEFAULT_DIV = 3;

    typedef enum logic [2:0] {
        STOP,
        RUN,
        DRAIN,
        HALT,
        LOAD
    } div_state_t;

endpackage

// File: rtl/clock_div_ctrl_if.sv
// Control/status bundle between the configuration requester and the divider controller.
interface clock_div_if #(
    parameter int CNT_W = clock_div_pkg::CNT_W
) ();

    logic             run_en;
    logic             div_req;
    logic [CNT_W-1:0] div_value;
    logic             div_ack;
    logic             clk_out;
    logic             rise_pls;
    logic             fall_pls;
    logic [CNT_W-1:0] cur_div;
    logic             busy;

    modport master (
        output run_en, div_req, div_value,
        input  div_ack, clk_out, rise_pls, fall_pls, cur_div, busy
    );

    modport slave (
        input  run_en, div_req, div_value,
        output div_ack, clk_out, rise_pls, fall_pls, cur_div, busy
    );

endinterface

// File: rtl/clock_div_ctrl_counter.sv
// Half-period counter with terminal-count compare, registered divided clock and edge strobes.
module clock_div_counter #(
    parameter int CNT_W = 4
) (
    input  logic             iCLK,
    input  logic             RST,
    input  logic             cnt_en,
    input  logic             cnt_clr,
    input  logic [CNT_W-1:0] div,
    output logic             tc,
    output logic             clk_out,
    output logic             rise_pls,
    output logic             fall_pls
);

    logic [CNT_W-1:0] count;
    logic             toggle;

    assign tc     = (count == div);
    assign toggle = cnt_en && !cnt_clr && tc;

    // A clear forces clk_out low; it only strobes a fall when clk_out was actually high.
    always_ff @(posedge iCLK) begin
        if (RST) begin
            count    <= '0;
            clk_out  <= 1'b0;
            rise_pls <= 1'b0;
            fall_pls <= 1'b0;
        end else begin
            rise_pls <= toggle && !clk_out;
            fall_pls <= (toggle || cnt_clr) && clk_out;
            if (cnt_clr) begin
                count   <= '0;
                clk_out <= 1'b0;
            end else if (cnt_en) begin
                if (tc) begin
                    count   <= '0;
                    clk_out <= ~clk_out;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/clock_div_ctrl.sv
// Divider controller: run/stop and ratio changes applied only at phase boundaries.
module clock_div_ctrl
    import clock_div_pkg::*;
#(
    parameter int CNT_W       = clock_div_pkg::CNT_W,
    parameter int DEFAULT_DIV = clock_div_pkg::DEFAULT_DIV
) (
    input  logic      iCLK,
    input  logic      RST,
    clock_div_if.slave bus
);

    div_state_t       state;
    div_state_t       next_state;
    logic             armed;
    logic             armed_req;
    logic             tc;
    logic             cnt_en;
    logic             cnt_clr;
    logic             load;
    logic             busy_nxt;
    logic [CNT_W-1:0] cur_div;

    assign armed_req   = bus.div_req && armed;
    assign bus.cur_div = cur_div;

    always_ff @(posedge iCLK) begin
        if (RST) begin
            state <= STOP;
        end else begin
            state <= next_state;
        end
    end

    // Requests outrank run_en in STOP/RUN; in HALT a returning run_en resumes untouched.
    always_comb begin
        next_state = state;
        case (state)
            STOP: begin
                if (armed_req)       next_state = LOAD;
                else if (bus.run_en) next_state = RUN;
            end
            RUN: begin
                if (armed_req)        next_state = DRAIN;
                else if (!bus.run_en) next_state = HALT;
            end
            DRAIN: begin
                if (tc) next_state = LOAD;
            end
            HALT: begin
                if (bus.run_en)     next_state = RUN;
                else if (tc)        next_state = STOP;
                else if (armed_req) next_state = DRAIN;
            end
            LOAD: begin
                next_state = bus.run_en ? RUN : STOP;
            end
            default: next_state = STOP;
        endcase
    end

    always_comb begin
        cnt_en   = (state == RUN) || (state == DRAIN) || (state == HALT);
        cnt_clr  = (state == STOP) || (state == LOAD) ||
                   ((state == DRAIN) && tc) ||
                   ((state == HALT) && !bus.run_en && tc);
        load     = (next_state == LOAD) && (state != LOAD);
        busy_nxt = (next_state == DRAIN) || (next_state == HALT) ||
                   (next_state == LOAD);
    end

    // The armed flag enforces a four-phase handshake: div_req must be seen low between loads.
    always_ff @(posedge iCLK) begin
        if (RST) begin
            cur_div     <= CNT_W'(DEFAULT_DIV);
            armed       <= 1'b1;
            bus.div_ack <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            bus.div_ack <= load;
            bus.busy    <= busy_nxt;
            if (load) begin
                cur_div <= bus.div_value;
                armed   <= 1'b0;
            end else if (!bus.div_req) begin
                armed   <= 1'b1;
            end
        end
    end

    clock_div_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .iCLK     (iCLK),
        .RST      (RST),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .div      (cur_div),
        .tc       (tc),
        .clk_out  (bus.clk_out),
        .rise_pls (bus.rise_pls),
        .fall_pls (bus.fall_pls)
    );

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Scoreboard bench for clock_div_ctrl: a phase-level reference model predicts every strobe/ack.
module tb_clock_div_ctrl;

    localparam int W     = clock_div_pkg::CNT_W;
    localparam int LIMIT = 100;

    typedef struct {
        int         cyc;
        bit         rise;
        bit         fall;
        bit         ack;
        bit         level;
        logic [W-1:0] div;
        bit         busy;
    } exp_t;

    logic iCLK = 1'b0;
    logic RST  = 1'b1;
    int   cyc  = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];

    clock_div_if #(.CNT_W(W)) bus ();

    clock_div_ctrl #(
        .CNT_W       (W),
        .DEFAULT_DIV (3)
    ) dut (
        .iCLK (iCLK),
        .RST  (RST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    // Reference model: clock level, cycles left in the current phase, and pending intent.
    bit           m_level, m_armed, m_active, m_pchg, m_pstop, m_inload;
    int           m_left;
    logic [W-1:0] m_div;
    bit           m_rise, m_fall, m_ack, m_busy;

    bit           cur_run;
    bit           cur_req;
    logic [W-1:0] cur_val;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic boundCheck(input string name, input int g);
        if (g >= LIMIT) begin
            n_total++;
            $display("[TB] FAIL %s: wait expired after %0d cycles, required < %0d", name, g, LIMIT);
        end
    endtask

    task automatic modelReset();
        m_level = 0; m_armed = 1; m_active = 0; m_pchg = 0; m_pstop = 0; m_inload = 0;
        m_left = 0; m_div = W'(3);
        m_rise = 0; m_fall = 0; m_ack = 0; m_busy = 0;
    endtask

    task automatic modelAdvance();
        if (m_left == 1) begin
            m_level = !m_level;
            if (m_level) m_rise = 1; else m_fall = 1;
            m_left = int'(m_div) + 1;
        end else begin
            m_left--;
        end
    endtask

    task automatic modelEndLow();
        if (m_level) m_fall = 1;
        m_level = 0;
    endtask

    task automatic modelStep(input bit run, input bit req, input logic [W-1:0] val);
        bit take, at_edge, loading;
        take    = req && m_armed;
        at_edge = (m_left == 1);
        loading = 0;
        m_rise = 0; m_fall = 0; m_ack = 0;
        if (m_inload) begin
            m_inload = 0;
            m_active = run;
            m_left   = int'(m_div) + 1;
        end else if (!m_active) begin
            if (take) loading = 1;
            else if (run) begin
                m_active = 1;
                m_left   = int'(m_div) + 1;
            end
        end else if (m_pchg) begin
            if (at_edge) begin modelEndLow(); loading = 1; end
            else m_left--;
        end else if (m_pstop && run) begin
            m_pstop = 0;
            modelAdvance();
        end else if (m_pstop) begin
            if (at_edge) begin modelEndLow(); m_active = 0; m_pstop = 0; end
            else begin
                m_left--;
                if (take) begin m_pstop = 0; m_pchg = 1; end
            end
        end else begin
            modelAdvance();
            if (take) m_pchg = 1;
            else if (!run) m_pstop = 1;
        end
        if (loading) begin
            m_div = val; m_ack = 1; m_armed = 0; m_inload = 1;
            m_pchg = 0; m_pstop = 0; m_active = 0;
        end else if (!req) begin
            m_armed = 1;
        end
        m_busy = m_pchg || m_pstop || m_inload;
    endtask

    task automatic applyStimulus(input bit rst, input bit run, input bit req, input logic [W-1:0] val);
        exp_t e;
        @(negedge iCLK);
        RST           = rst;
        bus.run_en    = run;
        bus.div_req   = req;
        bus.div_value = val;
        if (rst) modelReset();
        else begin
            modelStep(run, req, val);
            if (m_rise || m_fall || m_ack) begin
                e.cyc = cyc + 1; e.rise = m_rise; e.fall = m_fall; e.ack = m_ack;
                e.level = m_level; e.div = m_div; e.busy = m_busy;
                sb.push_back(e);
            end
        end
    endtask

    task automatic step();
        applyStimulus(1'b0, cur_run, cur_req, cur_val);
    endtask

    task automatic waitLevel(input bit lvl);
        int g = 0;
        while (m_level != lvl && g < LIMIT) begin step(); g++; end
        boundCheck("wait_level", g);
    endtask

    task automatic requestDiv(input logic [W-1:0] val);
        int g = 0;
        cur_req = 1; cur_val = val;
        do begin step(); g++; end while (!m_ack && g < LIMIT);
        boundCheck("wait_ack", g);
    endtask

    task automatic checkReset(input string tag);
        @(posedge iCLK); #2;
        checkOutput({tag, "_cur_div"}, bus.cur_div, 3);
        checkOutput({tag, "_clk_out"}, bus.clk_out, 0);
        checkOutput({tag, "_busy"}, bus.busy, 0);
        checkOutput({tag, "_div_ack"}, bus.div_ack, 0);
        checkOutput({tag, "_rise_pls"}, bus.rise_pls, 0);
        checkOutput({tag, "_fall_pls"}, bus.fall_pls, 0);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a strobe or an ack.
    initial begin
        exp_t e;
        forever begin
            @(posedge iCLK); #1;
            if (bus.rise_pls || bus.fall_pls || bus.div_ack) begin
                checkOutput("event_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("event_cycle", cyc, e.cyc);
                    checkOutput("rise_pls", bus.rise_pls, e.rise);
                    checkOutput("fall_pls", bus.fall_pls, e.fall);
                    checkOutput("div_ack", bus.div_ack, e.ack);
                    checkOutput("clk_out", bus.clk_out, e.level);
                    checkOutput("cur_div", bus.cur_div, e.div);
                    checkOutput("busy", bus.busy, e.busy);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                checkOutput("missing_event", int'(bus.rise_pls | bus.fall_pls | bus.div_ack), 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int hold = 0;
        bit got_ack = 0;
        cur_run = 0; cur_req = 0; cur_val = '0;
        bus.run_en = 0; bus.div_req = 0; bus.div_value = '0;
        modelReset();

        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkReset("reset");

        cur_run = 1;
        repeat (40) step();

        $display("[TB] change while high: 3 -> 1");
        waitLevel(1'b1);
        step();
        requestDiv(W'(1));
        cur_req = 0;
        repeat (20) step();

        requestDiv(W'(3));
        cur_req = 0;
        repeat (12) step();

        $display("[TB] change while low with held request: 3 -> 7");
        waitLevel(1'b1);
        waitLevel(1'b0);
        step();
        requestDiv(W'(7));
        repeat (40) step();
        cur_req = 0;
        repeat (40) step();

        $display("[TB] stop and resume");
        requestDiv(W'(3));
        cur_req = 0;
        repeat (10) step();
        waitLevel(1'b1);
        step();
        cur_run = 0;
        repeat (10) step();
        checkOutput("stopped_clk_out", bus.clk_out, 0);
        cur_run = 1;
        repeat (20) step();
        waitLevel(1'b1);
        cur_run = 0;
        step();
        step();
        cur_run = 1;
        repeat (30) step();

        $display("[TB] simultaneous request and stop");
        waitLevel(1'b1);
        cur_run = 0;
        requestDiv(W'(5));
        cur_req = 0;
        repeat (10) step();
        checkOutput("simul_cur_div", bus.cur_div, 5);
        checkOutput("simul_clk_out", bus.clk_out, 0);
        checkOutput("simul_busy", bus.busy, 0);

        $display("[TB] reset during DRAIN");
        cur_run = 1;
        repeat (5) step();
        waitLevel(1'b1);
        cur_req = 1; cur_val = W'(9);
        step();
        step();
        checkOutput("drain_busy", bus.busy, 1);
        applyStimulus(1'b1, cur_run, cur_req, cur_val);
        checkReset("reset_drain");
        cur_req = 0;
        cur_run = 0;
        step();
        cur_run = 1;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) cur_run = !cur_run;
            if (m_ack) begin
                got_ack = 1;
                hold = $urandom_range(0, 6);
            end
            if (cur_req && got_ack) begin
                if (hold == 0) begin
                    cur_req = 0;
                    got_ack = 0;
                end else begin
                    hold--;
                end
            end else if (!cur_req && $urandom_range(0, 19) == 0) begin
                cur_req = 1;
                cur_val = W'($urandom_range(0, (1 << W) - 1));
            end
            step();
        end

        cur_req = 0;
        repeat (5) step();
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clock_div_ctrl.md
# clock_div_ctrl

Runtime controller for the hash-core clock divider. It generates the divided clock `clk_out` from `iCLK` with a programmable half-period and supports start and stop. A requester can change the ratio through a req/ack handshake, and every change or stop takes effect only at a phase boundary, so `clk_out` never produces a pulse shorter than the shorter of the old and new half-periods. It sits between the configuration/control interface and the miner datapath, and also provides single-cycle edge strobes for logic that stays on `iCLK`.

## Interface
- `CNT_W`, default 4: counter and divisor width.
- `DEFAULT_DIV`, default 3: divisor loaded at reset. Half-period is DEFAULT_DIV+1 = 4, so full period is 8.
- `iCLK`  in  1  system clock.
- `RST`  in  1  reset, synchronous, active-high.
- `run_en`  in  1  level. 1 = run divider, 0 = stop at the next phase boundary.
- `div_req`  in  1  ratio-change request. Level signal, held until `div_ack`.
- `div_value`  in  CNT_W  new divisor D. Half-period is D+1 cycles. Must be stable while `div_req` is high.
- `div_ack`  out  1  one-cycle pulse: new divisor has been loaded.
- `clk_out`  out  1  divided clock, registered.
- `rise_pls`  out  1  high in the cycle in which `clk_out` first reads 1.
- `fall_pls`  out  1  high in the cycle in which `clk_out` first reads 0.
- `cur_div`  out  CNT_W  divisor currently in effect.
- `busy`  out  1  high in DRAIN, HALT and LOAD.

## Operation
- **States**
  - STOP: `clk_out`=0, counter=0.
  - RUN.
  - DRAIN: change pending.
  - HALT: stop pending.
  - LOAD: one cycle.
- **Counting** (RUN, DRAIN, HALT):
  - Terminal count (TC) is counter==cur_div.
  - At TC in RUN: counter←0 and `clk_out` toggles.
  - Otherwise counter increments.
- **Request arming**
  - A request is honoured only if `div_req` was sampled low at least once since the previous `div_ack` or since reset (four-phase handshake, via an internal armed flag).
  - The armed flag is set at reset.
- **Transitions**
  - STOP:
    - Armed request → LOAD.
    - Else `run_en` → RUN.
    - Request has priority over `run_en`.
  - RUN:
    - Armed request → DRAIN. Request has priority over `run_en`=0.
    - Else `run_en`=0 → HALT.
  - DRAIN:
    - At TC: counter←0, `clk_out`←0, `cur_div`←`div_value`, `div_ack`←1, go to LOAD.
    - If `clk_out` was already 0 at TC, no rise occurs; the low phase is extended.
  - HALT:
    - `run_en` back to 1 → RUN, with no disturbance to counter or `clk_out`.
    - At TC: `clk_out`←0, counter←0, go to STOP.
    - An armed request goes to DRAIN. The stop is then completed from LOAD.
  - LOAD:
    - counter held at 0, `clk_out`=0, `div_ack`=1.
    - Next state is RUN if `run_en`=1, else STOP.
  - From STOP → LOAD, the load happens on the transition. `cur_div` and `div_ack` update together.
- **Edge strobes**
  - `rise_pls` and `fall_pls` are registered alongside `clk_out`.
  - Never both high in the same cycle.
  - No `fall_pls` when `clk_out` was already 0.
- **Reset**, applied in any state (including mid-operation), on the next `iCLK` edge:
  - State STOP, counter 0, `clk_out` 0, `cur_div`=DEFAULT_DIV.
  - `div_ack`, `rise_pls`, `fall_pls` and `busy` all 0; armed flag 1.
  - A truncated high phase on reset is accepted.

## Timing
- Divisor D gives a half-period of D+1 cycles and a full period of 2(D+1).
- D=0 gives `iCLK`/2.
- Divisor-change latency from DRAIN entry to `div_ack` is at most D_old+1 cycles.
- The first high phase after LOAD begins 1 + (D_new+1) cycles after the LOAD cycle.
- Stop latency from HALT entry to STOP is at most D+1 cycles.
- `clk_out` ends low in all stop and change cases.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `clock_div_pkg` holds:
  - the state enum (STOP, RUN, DRAIN, HALT, LOAD);
  - `CNT_W`;
  - `DEFAULT_DIV`.
- Sub-module `clock_div_counter` contains the counter, TC compare, `clk_out` toggle and edge strobes.
- The `clock_div_counter` control inputs are: count enable, synchronous clear to (counter 0, `clk_out` 0), and the divisor.
- The FSM, armed flag and `cur_div` register live in `clock_div_ctrl`.

## Test plan
- **Reset, then run:** `RST` high for 2 cycles, then `run_en`=1.
  - Required: `cur_div`=3.
  - `clk_out` period is 8 cycles, 50% duty.
  - `rise_pls` is exactly one cycle wide at each rise.
- **Change while high:** D=3, request D=1 issued during the high phase.
  - Required: high phase completes at 4 cycles.
  - `div_ack` pulses once.
  - Subsequent period is 4 cycles, with the first low phase being 1+2 cycles.
- **Change while low, and rearm:** D=3, request D=7 issued in the low phase; `div_req` then held high after ack.
  - Required: no rise before LOAD; new period is 16.
  - A second ack does not occur until `div_req` has dropped.
- **Stop and resume:** drop `run_en` mid-high-phase.
  - Required: `clk_out` falls at TC and the block enters STOP.
  - Reasserting `run_en` during HALT resumes with an unchanged period.
- **Simultaneous request and stop:** `div_req` together with `run_en`=0 in RUN.
  - Required: DRAIN → LOAD → STOP.
  - `cur_div` = new value; `clk_out`=0.
- **Reset mid-DRAIN:**
  - Required: the next cycle shows STOP, `cur_div`=3, no `div_ack`.
